// File: rtl/sdram_pattern_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : sdram_pattern_checker
// Description : SDRAM exerciser. Writes a selectable data pattern over an
//               address window through the controller command interface,
//               reads the window back, and compares every returned word
//               against a regenerated pattern. Reports pass/fail, a
//               saturating error count and the first failing address/data.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_pattern_checker #(
  parameter int     AddrWidth        = 23,
  parameter int     DataWidth        = 16,
  parameter longint AddrCountLimit   = 'h800000,
  parameter int     MaxEnqueuedReads = 10,
  parameter int     ErrCountWidth    = 16,
  parameter int     LFSRSeed         = 'hACE1
) (
  input  logic                     clk12mhz,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic                     cmdReady,
  output logic                     cmdTrigger,
  output logic [AddrWidth-1:0]     cmdAddr,
  output logic                     cmdWrite,
  output logic [DataWidth-1:0]     cmdWriteData,
  input  logic [DataWidth-1:0]     cmdReadData,
  input  logic                     cmdReadDataValid,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ErrCountWidth-1:0] errCount,
  output logic [AddrWidth-1:0]     firstErrAddr,
  output logic [DataWidth-1:0]     firstErrData
);

  // Galois taps for x^16+x^14+x^13+x^11+1, scaled to the data width
  // (0xB400 at 16 bits); taps that fall below bit 0 are dropped.
  function automatic logic [DataWidth-1:0] lfsr_taps();
    logic [DataWidth-1:0] m;
    m = '0;
    for (int k = 0; k < DataWidth; k++) begin
      if (k == DataWidth-1 || k == DataWidth-3 || k == DataWidth-4 || k == DataWidth-6)
        m[k] = 1'b1;
    end
    return m;
  endfunction

  // 1010..b starting at the MSB.
  function automatic logic [DataWidth-1:0] alt_pattern();
    logic [DataWidth-1:0] m;
    m = '0;
    for (int k = 0; k < DataWidth; k++) begin
      m[k] = (((DataWidth - 1 - k) % 2) == 0);
    end
    return m;
  endfunction

  localparam int                   c_out_w      = $clog2(MaxEnqueuedReads + 1);
  localparam logic [AddrWidth:0]   c_last_addr  = (AddrWidth+1)'(AddrCountLimit - 1);
  localparam logic [AddrWidth:0]   c_idx_one    = (AddrWidth+1)'(1);
  localparam logic [c_out_w-1:0]   c_out_one    = c_out_w'(1);
  localparam logic [c_out_w-1:0]   c_out_max    = c_out_w'(MaxEnqueuedReads);
  localparam logic [ErrCountWidth-1:0] c_err_one = ErrCountWidth'(1);
  localparam logic [DataWidth-1:0] c_seed_trunc = DataWidth'(LFSRSeed);
  localparam logic [DataWidth-1:0] c_seed       = (c_seed_trunc == '0) ? DataWidth'(1) : c_seed_trunc;
  localparam logic [DataWidth-1:0] c_lfsr_taps  = lfsr_taps();
  localparam logic [DataWidth-1:0] c_alt        = alt_pattern();

  function automatic logic [DataWidth-1:0] lfsr_next(input logic [DataWidth-1:0] v);
    return (v >> 1) ^ (v[0] ? c_lfsr_taps : '0);
  endfunction

  // Pattern word for index idx; mode 2 takes the current LFSR state since
  // that sequence depends on history rather than on the index alone.
  function automatic logic [DataWidth-1:0] pattern(input logic [1:0]           m,
                                                   input logic [AddrWidth:0]   idx,
                                                   input logic [DataWidth-1:0] lfsr);
    case (m)
      2'd0:    return DataWidth'(idx);
      2'd1:    return ~DataWidth'(idx);
      2'd2:    return lfsr;
      default: return idx[0] ? ~c_alt : c_alt;
    endcase
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               mode_q, mode_d;
  logic [AddrWidth:0]       addr_q, addr_d;
  logic                     trig_q, trig_d;
  logic                     write_q, write_d;
  logic [DataWidth-1:0]     wdata_q, wdata_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     pass_q, pass_d;
  logic [ErrCountWidth-1:0] err_q, err_d;
  logic [AddrWidth-1:0]     ferr_addr_q, ferr_addr_d;
  logic [DataWidth-1:0]     ferr_data_q, ferr_data_d;
  logic [c_out_w-1:0]       out_q, out_d;
  logic [DataWidth-1:0]     gen_lfsr_q, gen_lfsr_d;
  logic [DataWidth-1:0]     chk_lfsr_q, chk_lfsr_d;
  logic [AddrWidth:0]       chk_idx_q, chk_idx_d;

  logic                     w_accept;
  logic                     w_read_accept;
  logic                     w_ret;
  logic [c_out_w-1:0]       w_out_next;
  logic [DataWidth-1:0]     w_expected;
  logic [DataWidth-1:0]     w_gen_step;

  // Next-state, command generation, outstanding tracking and read checking.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    addr_d      = addr_q;
    trig_d      = trig_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_d       = err_q;
    ferr_addr_d = ferr_addr_q;
    ferr_data_d = ferr_data_q;
    out_d       = out_q;
    gen_lfsr_d  = gen_lfsr_q;
    chk_lfsr_d  = chk_lfsr_q;
    chk_idx_d   = chk_idx_q;

    w_accept      = trig_q && cmdReady;
    w_read_accept = w_accept && (state_q == ST_READ);
    // Returns only count while reads can be in flight; a stray pulse with
    // nothing outstanding is dropped so the counter never underflows.
    w_ret         = cmdReadDataValid && (out_q != '0) &&
                    ((state_q == ST_READ) || (state_q == ST_DRAIN));
    w_out_next    = out_q;
    if (w_read_accept && !w_ret)
      w_out_next = out_q + c_out_one;
    else if (!w_read_accept && w_ret)
      w_out_next = out_q - c_out_one;
    w_expected    = pattern(mode_q, chk_idx_q, chk_lfsr_q);
    w_gen_step    = lfsr_next(gen_lfsr_q);

    if (w_ret) begin
      chk_idx_d  = chk_idx_q + c_idx_one;
      chk_lfsr_d = lfsr_next(chk_lfsr_q);
      if (cmdReadData != w_expected) begin
        if (err_q != '1)
          err_d = err_q + c_err_one;
        if (err_q == '0) begin
          ferr_addr_d = chk_idx_q[AddrWidth-1:0];
          ferr_data_d = cmdReadData;
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_WRITE;
          mode_d      = mode;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_d       = '0;
          ferr_addr_d = '0;
          ferr_data_d = '0;
          out_d       = '0;
          busy_d      = 1'b1;
          trig_d      = 1'b1;
          write_d     = 1'b1;
          addr_d      = '0;
          gen_lfsr_d  = c_seed;
          wdata_d     = pattern(mode, '0, c_seed);
        end
      end
      ST_WRITE: begin
        if (w_accept) begin
          if (addr_q == c_last_addr) begin
            // Straight into the read pass; nothing is outstanding yet.
            state_d    = ST_READ;
            write_d    = 1'b0;
            addr_d     = '0;
            trig_d     = 1'b1;
            chk_idx_d  = '0;
            chk_lfsr_d = c_seed;
          end else begin
            addr_d     = addr_q + c_idx_one;
            gen_lfsr_d = w_gen_step;
            wdata_d    = pattern(mode_q, addr_q + c_idx_one, w_gen_step);
          end
        end
      end
      ST_READ: begin
        out_d = w_out_next;
        if (w_accept && (addr_q == c_last_addr)) begin
          trig_d  = 1'b0;
          state_d = ST_DRAIN;
        end else begin
          if (w_accept)
            addr_d = addr_q + c_idx_one;
          // Registered throttle: a return that frees a slot lets the
          // trigger rise on the following cycle.
          trig_d = (w_out_next < c_out_max);
        end
      end
      ST_DRAIN: begin
        out_d = w_out_next;
        if (out_q == '0)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_q == '0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk12mhz) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= '0;
      addr_q      <= '0;
      trig_q      <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
      out_q       <= '0;
      gen_lfsr_q  <= c_seed;
      chk_lfsr_q  <= c_seed;
      chk_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      addr_q      <= addr_d;
      trig_q      <= trig_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      ferr_addr_q <= ferr_addr_d;
      ferr_data_q <= ferr_data_d;
      out_q       <= out_d;
      gen_lfsr_q  <= gen_lfsr_d;
      chk_lfsr_q  <= chk_lfsr_d;
      chk_idx_q   <= chk_idx_d;
    end
  end

  assign cmdTrigger   = trig_q;
  assign cmdAddr      = addr_q[AddrWidth-1:0];
  assign cmdWrite     = write_q;
  assign cmdWriteData = wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign errCount     = err_q;
  assign firstErrAddr = ferr_addr_q;
  assign firstErrData = ferr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_pattern_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sdram_pattern_checker
// Description : Bench for sdram_pattern_checker with a behavioural SDRAM
//               model (random ready, in-order delayed returns, injectable
//               corruption) and a reference pattern generator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_pattern_checker;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int N = 16;
  localparam int MAXQ = 2;
  localparam int EW = 2;

  logic          clk12mhz = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          cmdReady = 1'b0;
  logic          cmdTrigger;
  logic [AW-1:0] cmdAddr;
  logic          cmdWrite;
  logic [DW-1:0] cmdWriteData;
  logic [DW-1:0] cmdReadData = '0;
  logic          cmdReadDataValid = 1'b0;
  logic          busy, done, pass;
  logic [EW-1:0] errCount;
  logic [AW-1:0] firstErrAddr;
  logic [DW-1:0] firstErrData;

  sdram_pattern_checker #(
    .AddrWidth(AW), .DataWidth(DW), .AddrCountLimit(N),
    .MaxEnqueuedReads(MAXQ), .ErrCountWidth(EW), .LFSRSeed('hACE1)
  ) dut (
    .clk12mhz(clk12mhz), .rst(rst), .start(start), .mode(mode),
    .cmdReady(cmdReady), .cmdTrigger(cmdTrigger), .cmdAddr(cmdAddr),
    .cmdWrite(cmdWrite), .cmdWriteData(cmdWriteData),
    .cmdReadData(cmdReadData), .cmdReadDataValid(cmdReadDataValid),
    .busy(busy), .done(done), .pass(pass), .errCount(errCount),
    .firstErrAddr(firstErrAddr), .firstErrData(firstErrData)
  );

  initial forever #41 clk12mhz = ~clk12mhz;

  typedef struct { int due; logic [DW-1:0] data; int run; } ret_t;
  ret_t          rq[$];
  int            checks = 0, errors = 0, cyc = 0;
  int            ready_pct = 100, lat_min = 3, lat_max = 3;
  bit            active = 1'b0;
  int            run_id = 0;
  logic [DW-1:0] mem[N];
  logic [DW-1:0] corrupt[N];
  logic [DW-1:0] lfsr_seq[N];
  int            wr_acc[N], rd_acc[N];
  int            writes = 0, reads = 0, outst = 0, max_out = 0;
  int            viol_stable = 0, viol_trig = 0;
  logic          prev_trig = 1'b0, prev_ready = 1'b0, prev_write = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;

  // Reference word for index i under mode m.
  function automatic logic [DW-1:0] ref_pat(input int m, input int i);
    logic [DW-1:0] v;
    v = DW'(i);
    case (m)
      0:       return v;
      1:       return ~v;
      2:       return lfsr_seq[i];
      default: return (i % 2 == 1) ? 16'h5555 : 16'hAAAA;
    endcase
  endfunction

  // SDRAM model: observes the bus on falling edges, decides ready for the
  // next rising edge, stores writes, and returns reads in order after a
  // random latency. Returns from a previous (aborted) run are still driven.
  initial forever begin
    @(negedge clk12mhz);
    cyc++;
    if (active && !rst) begin
      if (prev_trig && !prev_ready &&
          (cmdTrigger !== 1'b1 || cmdAddr !== prev_addr ||
           cmdWrite !== prev_write || cmdWriteData !== prev_data))
        viol_stable++;
      if (writes == N && reads < N) begin
        if (outst >= MAXQ && cmdTrigger !== 1'b0) viol_trig++;
        if (outst <  MAXQ && cmdTrigger !== 1'b1) viol_trig++;
      end
      if (outst > max_out) max_out = outst;
    end
    prev_trig  = cmdTrigger;
    prev_addr  = cmdAddr;
    prev_write = cmdWrite;
    prev_data  = cmdWriteData;
    cmdReady   = (int'($urandom_range(0, 99)) < ready_pct);
    prev_ready = cmdReady;
    if (active && !rst && cmdTrigger === 1'b1 && cmdReady) begin
      if (cmdWrite) begin
        mem[cmdAddr] = cmdWriteData;
        wr_acc[cmdAddr]++;
        writes++;
      end else begin
        rq.push_back('{cyc + int'($urandom_range(lat_min, lat_max)),
                       mem[cmdAddr] ^ corrupt[cmdAddr], run_id});
        rd_acc[cmdAddr]++;
        reads++;
        outst++;
      end
    end
    cmdReadDataValid = 1'b0;
    cmdReadData      = DW'($urandom);
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      cmdReadDataValid = 1'b1;
      cmdReadData      = rq[0].data;
      if (rq[0].run == run_id) outst--;
      void'(rq.pop_front());
    end
  end

  task automatic begin_run(input logic [1:0] m);
    @(negedge clk12mhz); #1;
    run_id++;
    writes = 0; reads = 0; outst = 0; max_out = 0; viol_stable = 0; viol_trig = 0;
    for (int i = 0; i < N; i++) begin
      wr_acc[i] = 0; rd_acc[i] = 0; mem[i] = '0;
    end
    active = 1'b1;
    mode   = m;
    start  = 1'b1;
    @(negedge clk12mhz); #1;
    start  = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 3000 && done !== 1'b1; k++) @(negedge clk12mhz);
    #1;
  endtask

  function automatic int acc_bad();
    int b;
    b = 0;
    for (int i = 0; i < N; i++) if (wr_acc[i] != 1 || rd_acc[i] != 1) b++;
    return b;
  endfunction

  function automatic int mem_bad(input int m);
    int b;
    b = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== ref_pat(m, i)) b++;
    return b;
  endfunction

  task automatic clear_corrupt();
    for (int i = 0; i < N; i++) corrupt[i] = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk12mhz);
    #1;
    checks++; if ({cmdTrigger, cmdWrite, cmdAddr, cmdWriteData} !== '0) begin errors++; $display("FAIL reset_cmd got %b/%b/%h/%h exp 0", cmdTrigger, cmdWrite, cmdAddr, cmdWriteData); end
    checks++; if ({busy, done, pass} !== 3'b000) begin errors++; $display("FAIL reset_status got busy %b done %b pass %b exp 000", busy, done, pass); end
    checks++; if (errCount !== '0) begin errors++; $display("FAIL reset_errcount got %0d exp 0", errCount); end
    checks++; if ({firstErrAddr, firstErrData} !== '0) begin errors++; $display("FAIL reset_firsterr got %h/%h exp 0", firstErrAddr, firstErrData); end
    rst = 1'b0;
  endtask

  task automatic test_ideal();
    ready_pct = 100; lat_min = 3; lat_max = 3; clear_corrupt();
    begin_run(2'd0);
    wait_done();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ideal_done got done %b busy %b exp 1 0", done, busy); end
    checks++; if (pass !== 1'b1 || errCount !== '0) begin errors++; $display("FAIL ideal_pass got pass %b err %0d exp 1 0", pass, errCount); end
    for (int i = 0; i < N; i++) begin
      checks++; if (mem[i] !== DW'(i)) begin errors++; $display("FAIL ideal_wdata[%0d] got %h exp %h", i, mem[i], DW'(i)); end
    end
    checks++; if (acc_bad() != 0) begin errors++; $display("FAIL ideal_accepts got %0d bad addrs exp 0", acc_bad()); end
    checks++; if (viol_trig != 0) begin errors++; $display("FAIL ideal_throttle got %0d exp 0", viol_trig); end
  endtask

  task automatic test_random_ready();
    int m;
    for (int r = 0; r < 3; r++) begin
      m = int'($urandom_range(0, 3));
      ready_pct = 50; lat_min = 1; lat_max = 5; clear_corrupt();
      begin_run(2'(m));
      wait_done();
      checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL rnd_pass mode %0d got done %b pass %b exp 1 1", m, done, pass); end
      checks++; if (viol_stable != 0) begin errors++; $display("FAIL rnd_stable got %0d exp 0", viol_stable); end
      checks++; if (acc_bad() != 0) begin errors++; $display("FAIL rnd_accepts got %0d bad addrs exp 0", acc_bad()); end
      checks++; if (mem_bad(m) != 0) begin errors++; $display("FAIL rnd_wdata mode %0d got %0d bad words exp 0", m, mem_bad(m)); end
    end
  endtask

  task automatic test_throttle();
    ready_pct = 100; lat_min = 8; lat_max = 8; clear_corrupt();
    begin_run(2'($urandom_range(0, 3)));
    wait_done();
    checks++; if (max_out != MAXQ) begin errors++; $display("FAIL thr_maxout got %0d exp %0d", max_out, MAXQ); end
    checks++; if (viol_trig != 0) begin errors++; $display("FAIL thr_trigger got %0d exp 0", viol_trig); end
    checks++; if (pass !== 1'b1 || acc_bad() != 0) begin errors++; $display("FAIL thr_pass got pass %b bad %0d exp 1 0", pass, acc_bad()); end
  endtask

  task automatic test_corrupt();
    ready_pct = 70; lat_min = 2; lat_max = 4; clear_corrupt();
    corrupt[5] = 16'h0001;
    corrupt[9] = 16'h0100;
    begin_run(2'd1);
    wait_done();
    checks++; if (done !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL corr_pass got done %b pass %b exp 1 0", done, pass); end
    checks++; if (errCount !== 2'd2) begin errors++; $display("FAIL corr_errcount got %0d exp 2", errCount); end
    checks++; if (firstErrAddr !== 4'd5) begin errors++; $display("FAIL corr_addr got %0d exp 5", firstErrAddr); end
    checks++; if (firstErrData !== 16'hFFFB) begin errors++; $display("FAIL corr_data got %h exp fffb", firstErrData); end
    clear_corrupt();
  endtask

  task automatic test_lfsr_and_alt();
    ready_pct = 60; lat_min = 1; lat_max = 6; clear_corrupt();
    begin_run(2'd2);
    wait_done();
    for (int i = 0; i < N; i++) begin
      checks++; if (mem[i] !== lfsr_seq[i]) begin errors++; $display("FAIL lfsr_wdata[%0d] got %h exp %h", i, mem[i], lfsr_seq[i]); end
    end
    checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL lfsr_pass got done %b pass %b exp 1 1", done, pass); end
    begin_run(2'd3);
    wait_done();
    checks++; if (mem[0] !== 16'hAAAA || mem[1] !== 16'h5555) begin errors++; $display("FAIL alt_first got %h %h exp aaaa 5555", mem[0], mem[1]); end
    checks++; if (mem_bad(3) != 0) begin errors++; $display("FAIL alt_wdata got %0d bad words exp 0", mem_bad(3)); end
    checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL alt_pass got done %b pass %b exp 1 1", done, pass); end
  endtask

  task automatic test_saturate();
    int idx[N];
    int m, t, j, first;
    logic [DW-1:0] fdata;
    for (int i = 0; i < N; i++) idx[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = idx[i]; idx[i] = idx[j]; idx[j] = t;
    end
    m = int'($urandom_range(0, 3));
    ready_pct = 80; lat_min = 1; lat_max = 4; clear_corrupt();
    first = N;
    for (int k = 0; k < 5; k++) begin
      corrupt[idx[k]] = DW'($urandom_range(1, 65535));
      if (idx[k] < first) first = idx[k];
    end
    fdata = ref_pat(m, first) ^ corrupt[first];
    begin_run(2'(m));
    wait_done();
    checks++; if (errCount !== 2'd3) begin errors++; $display("FAIL sat_errcount got %0d exp 3", errCount); end
    checks++; if (firstErrAddr !== AW'(first) || firstErrData !== fdata) begin errors++; $display("FAIL sat_firsterr got %0d/%h exp %0d/%h", firstErrAddr, firstErrData, first, fdata); end
    checks++; if (done !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL sat_pass got done %b pass %b exp 1 0", done, pass); end
    clear_corrupt();
  endtask

  task automatic test_reset_mid_read();
    int m;
    bit reached;
    ready_pct = 100; lat_min = 8; lat_max = 8; clear_corrupt();
    begin_run(2'($urandom_range(0, 3)));
    reached = 1'b0;
    for (int k = 0; k < 500 && !reached; k++) begin
      @(negedge clk12mhz); #1;
      reached = (writes == N && outst == MAXQ);
    end
    checks++; if (!reached) begin errors++; $display("FAIL mid_reach got outstanding %0d exp %0d", outst, MAXQ); end
    rst = 1'b1;
    active = 1'b0;
    @(negedge clk12mhz); #1;
    checks++; if ({cmdTrigger, cmdWrite, cmdAddr, cmdWriteData} !== '0) begin errors++; $display("FAIL mid_rst_cmd got %b/%b/%h/%h exp 0", cmdTrigger, cmdWrite, cmdAddr, cmdWriteData); end
    checks++; if ({busy, done, pass, errCount, firstErrAddr, firstErrData} !== '0) begin errors++; $display("FAIL mid_rst_status got busy %b done %b err %0d exp 0", busy, done, errCount); end
    rst = 1'b0;
    m = int'($urandom_range(0, 3));
    begin_run(2'(m));
    wait_done();
    checks++; if (done !== 1'b1 || pass !== 1'b1 || errCount !== '0) begin errors++; $display("FAIL mid_rerun got done %b pass %b err %0d exp 1 1 0", done, pass, errCount); end
    checks++; if (mem_bad(m) != 0 || acc_bad() != 0) begin errors++; $display("FAIL mid_rerun_data got %0d/%0d bad exp 0/0", mem_bad(m), acc_bad()); end
  endtask

  initial begin
    logic [DW-1:0] v;
    v = 16'hACE1;
    for (int i = 0; i < N; i++) begin
      lfsr_seq[i] = v;
      v = (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    end
    clear_corrupt();
    test_reset();
    test_ideal();
    test_random_ready();
    test_throttle();
    test_corrupt();
    test_lfsr_and_alt();
    test_saturate();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
